// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
package adc_sched_pkg;

   localparam int ADC_DATA_W = 10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   // Clock cycles per sample period; truncates like the integer divide it is.
   function automatic int sample_div(input int clk_freq, input int sample_rate);
      return clk_freq / sample_rate;
   endfunction

endpackage

// File: rtl/adc_sample_scheduler_if.sv
// ADC driver handshake plus the downstream sample stream.
interface adc_sample_scheduler_if;
   import adc_sched_pkg::*;

   logic                  adc_enable;
   logic                  adc_clear_available;
   logic                  adc_available;
   logic [ADC_DATA_W-1:0] adc_data;
   logic [ADC_DATA_W-1:0] sample_data;
   logic                  sample_valid;
   logic                  sample_ready;

   modport master (
      output adc_enable, adc_clear_available, sample_data, sample_valid,
      input  adc_available, adc_data, sample_ready
   );

   modport slave (
      input  adc_enable, adc_clear_available, sample_data, sample_valid,
      output adc_available, adc_data, sample_ready
   );

endinterface

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module sample_fifo #(
   parameter  int WIDTH = 10,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]               level_q, level_d;
   logic                        do_push, do_pop;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   always_comb begin
      empty   = (level_q == '0);
      full    = (level_q == LW'(DEPTH));
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      level_d = level_q;
      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      level_d = level_q + 1'b1;
      else if (do_pop && !do_push) level_d = level_q - 1'b1;
   end

   // Storage and pointers; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign level = level_q;

endmodule

// File: rtl/adc_sample_scheduler.sv
// Paces MCP3002 conversions at SAMPLE_RATE, times out stalled ones, buffers results.
module adc_sample_scheduler
   import adc_sched_pkg::*;
#(
   parameter  int CLK_FREQ       = 27_000_000,
   parameter  int SAMPLE_RATE    = 48_000,
   parameter  int TIMEOUT_CYCLES = 1023,
   parameter  int FIFO_DEPTH     = 4,
   localparam int SAMPLE_DIV     = sample_div(CLK_FREQ, SAMPLE_RATE),
   localparam int CNT_W          = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1,
   localparam int TMR_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1,
   localparam int LVL_W          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   adc_sample_scheduler_if.master bus,
   output logic [LVL_W-1:0]       fifo_level,
   output logic                   overrun,
   output logic                   missed,
   output logic                   timeout_err,
   input  logic                   err_clear
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             en_q, en_d;
   logic             overrun_q, overrun_d, missed_q, missed_d, timeout_q, timeout_d;
   logic             tick, push, timeout_hit, fifo_full, fifo_empty, fifo_drop;

   // Period counter parks on its last count while idle so the first run cycle ticks.
   always_comb begin
      tick = run && (cnt_q == CNT_LAST);
      if (!run)      cnt_d = CNT_LAST;
      else if (tick) cnt_d = '0;
      else           cnt_d = cnt_q + 1'b1;
   end

   // Next state: arm on tick, wait for available or timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (tick) state_d = S_ARM;
         S_ARM:   state_d = S_WAIT;
         S_WAIT:  if (bus.adc_available || timeout_hit) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs; available is ignored in S_ARM because the driver clears it then.
   always_comb begin
      en_d        = (state_q == S_IDLE) && tick;
      tmr_d       = tmr_q;
      if (state_q == S_ARM)       tmr_d = '0;
      else if (state_q == S_WAIT) tmr_d = tmr_q + 1'b1;
      push        = (state_q == S_WAIT) && bus.adc_available;
      timeout_hit = (state_q == S_WAIT) && !bus.adc_available && (tmr_q == TMR_LAST);
   end

   // Sticky error flags; a new event beats a simultaneous clear.
   always_comb begin
      fifo_drop = push && fifo_full && !bus.sample_ready;
      overrun_d = fifo_drop | (overrun_q & ~err_clear);
      missed_d  = (tick && state_q != S_IDLE) | (missed_q & ~err_clear);
      timeout_d = timeout_hit | (timeout_q & ~err_clear);
   end

   // State register together with counter, timer, pulse and flag flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= CNT_LAST;
         tmr_q     <= '0;
         en_q      <= 1'b0;
         overrun_q <= 1'b0;
         missed_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         en_q      <= en_d;
         overrun_q <= overrun_d;
         missed_q  <= missed_d;
         timeout_q <= timeout_d;
      end
   end

   sample_fifo #(
      .WIDTH (ADC_DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.adc_data),
      .pop       (bus.sample_ready),
      .head      (bus.sample_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign bus.adc_enable          = en_q;
   assign bus.adc_clear_available = en_q;
   assign bus.sample_valid        = !fifo_empty;
   assign overrun                 = overrun_q;
   assign missed                  = missed_q;
   assign timeout_err             = timeout_q;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: ADC model with fixed latency plus a queue-based sample reference.
module tb_adc_sample_scheduler;
   import adc_sched_pkg::*;

   localparam int DIV0    = 27_000_000 / 48_000;   // 562
   localparam int DIV1    = 27_000_000 / 67_500;   // 400, shorter than a conversion
   localparam int TMO     = 1023;
   localparam int ADC_LAT = 480;
   localparam int DEPTH   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run0 = 1'b0, run1 = 1'b0, errc0 = 1'b0, errc1 = 1'b0;
   logic [2:0] lvl0, lvl1;
   logic ovr0, mis0, tmo0, ovr1, mis1, tmo1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   adc_sample_scheduler_if bus0();
   adc_sample_scheduler_if bus1();

   adc_sample_scheduler #(.CLK_FREQ(27_000_000), .SAMPLE_RATE(48_000),
                          .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut0 (
      .clk(clk), .rst(rst), .run(run0), .bus(bus0), .fifo_level(lvl0),
      .overrun(ovr0), .missed(mis0), .timeout_err(tmo0), .err_clear(errc0));

   adc_sample_scheduler #(.CLK_FREQ(27_000_000), .SAMPLE_RATE(67_500),
                          .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut1 (
      .clk(clk), .rst(rst), .run(run1), .bus(bus1), .fifo_level(lvl1),
      .overrun(ovr1), .missed(mis1), .timeout_err(tmo1), .err_clear(errc1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- ADC model: available ADC_LAT clk after the enable pulse
   logic [1:0] m_en, m_clr, m_av;
   logic [9:0] m_dat [2];
   bit         m_busy [2];
   int         m_dly [2];
   bit         hang [2];
   logic [9:0] nxt [2];
   logic [9:0] ret0 [$];
   logic [9:0] ret1 [$];
   logic [9:0] exp_q [$];

   assign m_en  = {bus1.adc_enable, bus0.adc_enable};
   assign m_clr = {bus1.adc_clear_available, bus0.adc_clear_available};
   assign bus0.adc_available = m_av[0];
   assign bus0.adc_data      = m_dat[0];
   assign bus1.adc_available = m_av[1];
   assign bus1.adc_data      = m_dat[1];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_av[k]   <= 1'b1;      // flag is high after ADC reset
            m_dat[k]  <= 10'h3FF;   // stale content that must never be sampled
            m_busy[k] <= 1'b0;
            m_dly[k]  <= 0;
         end else begin
            if (m_clr[k]) m_av[k] <= 1'b0;
            if (m_en[k]) begin
               m_busy[k] <= !hang[k];
               m_dly[k]  <= ADC_LAT - 1;
            end else if (m_busy[k]) begin
               if (m_dly[k] == 0) begin
                  m_av[k]   <= 1'b1;
                  m_dat[k]  <= nxt[k];
                  m_busy[k] <= 1'b0;
                  if (k == 0) ret0.push_back(nxt[k]);
                  else        ret1.push_back(nxt[k]);
               end else begin
                  m_dly[k] <= m_dly[k] - 1;
               end
            end
         end
      end
   end

   function automatic bit sig(input int sel);
      case (sel)
         0:       return bus0.adc_enable;
         1:       return bus0.adc_available;
         2:       return tmo0;
         3:       return bus1.adc_enable;
         4:       return bus1.adc_available;
         default: return 1'b0;
      endcase
   endfunction

   // Bounded wait: n = negedges until the selected signal is seen high.
   task automatic wait_sig(input int sel, input int maxc, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < maxc) begin
         @(negedge clk);
         n++;
         if (sig(sel)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; run0 = 1'b0; run1 = 1'b0; errc0 = 1'b0; errc1 = 1'b0;
      bus0.sample_ready = 1'b0; bus1.sample_ready = 1'b0;
      hang[0] = 1'b0; hang[1] = 1'b0;
      nxt[0] = 10'($urandom); nxt[1] = 10'($urandom);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ret0.delete(); ret1.delete(); exp_q.delete();
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      rst = 1'b1; run0 = 1'b0; bus0.sample_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus0.adc_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", bus0.adc_enable); end
      checks++; if (bus0.adc_clear_available !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b want 0", bus0.adc_clear_available); end
      checks++; if (bus0.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus0.sample_valid); end
      checks++; if (bus0.sample_data !== 10'h0) begin errors++; $display("FAIL reset_data: got %h want 000", bus0.sample_data); end
      checks++; if (lvl0 !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", lvl0); end
      checks++; if ({ovr0, mis0, tmo0} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {ovr0, mis0, tmo0}); end
   endtask

   task automatic test_basic();
      int n, t1;
      bit ok;
      do_reset();
      bus0.sample_ready = 1'b1;
      nxt[0] = 10'h155;
      run0 = 1'b1;
      wait_sig(0, 4, n, ok);
      checks++; if (!ok || n != 1) begin errors++; $display("FAIL basic_first_pulse: got %0d cycles (seen %0d) want 1", n, ok); end
      checks++; if (bus0.adc_clear_available !== 1'b1) begin errors++; $display("FAIL basic_clear_coincident: got %b want 1", bus0.adc_clear_available); end
      t1 = cyc;
      @(negedge clk);
      checks++; if ({bus0.adc_enable, bus0.adc_clear_available} !== 2'b00) begin errors++; $display("FAIL basic_pulse_width: got %b want 00", {bus0.adc_enable, bus0.adc_clear_available}); end
      wait_sig(1, ADC_LAT + 10, n, ok);
      checks++; if (!ok || bus0.sample_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: valid %b seen %0d want valid 0", bus0.sample_valid, ok); end
      @(negedge clk);
      checks++; if (bus0.sample_valid !== 1'b1 || bus0.sample_data !== 10'h155) begin errors++; $display("FAIL basic_sample1: got v=%b d=%h want v=1 d=155", bus0.sample_valid, bus0.sample_data); end
      nxt[0] = 10'h2AA;
      wait_sig(0, DIV0, n, ok);
      checks++; if (!ok || cyc - t1 != DIV0) begin errors++; $display("FAIL basic_period: got %0d want %0d", cyc - t1, DIV0); end
      wait_sig(1, ADC_LAT + 10, n, ok);
      @(negedge clk);
      checks++; if (!ok || bus0.sample_valid !== 1'b1 || bus0.sample_data !== 10'h2AA) begin errors++; $display("FAIL basic_sample2: got v=%b d=%h want v=1 d=2aa", bus0.sample_valid, bus0.sample_data); end
      checks++; if ({ovr0, mis0, tmo0} !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b want 000", {ovr0, mis0, tmo0}); end
      run0 = 1'b0;
   endtask

   task automatic test_timeout();
      int n, t1, gap;
      bit ok;
      logic [9:0] v;
      do_reset();
      bus0.sample_ready = 1'b1;
      hang[0] = 1'b1;
      run0 = 1'b1;
      wait_sig(0, 4, n, ok);
      t1 = cyc;
      wait_sig(2, TMO + 20, n, ok);
      checks++; if (!ok || n != TMO + 1) begin errors++; $display("FAIL timeout_rise: got %0d want %0d clk after arm", n, TMO + 1); end
      checks++; if (lvl0 !== 3'd0 || bus0.sample_valid !== 1'b0) begin errors++; $display("FAIL timeout_nopush: got lvl=%0d v=%b want 0 0", lvl0, bus0.sample_valid); end
      checks++; if (mis0 !== (DIV0 <= TMO + 1)) begin errors++; $display("FAIL timeout_missed: got %b want %b", mis0, DIV0 <= TMO + 1); end
      hang[0] = 1'b0;
      nxt[0] = 10'($urandom);
      gap = ((TMO + 2 + DIV0 - 1) / DIV0) * DIV0;
      wait_sig(0, 2 * DIV0, n, ok);
      checks++; if (!ok || cyc - t1 != gap) begin errors++; $display("FAIL timeout_rearm: got %0d want %0d", cyc - t1, gap); end
      wait_sig(1, ADC_LAT + 10, n, ok);
      @(negedge clk);
      v = (ret0.size() > 0) ? ret0.pop_front() : 10'h0;
      checks++; if (!ok || bus0.sample_valid !== 1'b1 || bus0.sample_data !== v) begin errors++; $display("FAIL timeout_next_sample: got v=%b d=%h want v=1 d=%h", bus0.sample_valid, bus0.sample_data, v); end
      checks++; if (tmo0 !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", tmo0); end
      errc0 = 1'b1;
      @(negedge clk);
      errc0 = 1'b0;
      checks++; if ({tmo0, mis0} !== 2'b00) begin errors++; $display("FAIL timeout_clear: got %b want 00", {tmo0, mis0}); end
      run0 = 1'b0;
   endtask

   task automatic test_overrun();
      int n;
      bit ok, exp_ovr;
      logic [9:0] v;
      do_reset();
      run0 = 1'b1;
      exp_ovr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         nxt[0] = 10'($urandom);
         wait_sig(0, DIV0 + 2, n, ok);
         wait_sig(1, ADC_LAT + 10, n, ok);
         @(negedge clk);
         v = (ret0.size() > 0) ? ret0.pop_front() : 10'h0;
         if (exp_q.size() < DEPTH) exp_q.push_back(v);
         else                      exp_ovr = 1'b1;
         checks++; if (!ok || lvl0 !== 3'(exp_q.size())) begin errors++; $display("FAIL overrun_level%0d: got %0d want %0d", i, lvl0, exp_q.size()); end
         checks++; if (bus0.sample_data !== exp_q[0]) begin errors++; $display("FAIL overrun_head%0d: got %h want %h", i, bus0.sample_data, exp_q[0]); end
         checks++; if (ovr0 !== exp_ovr) begin errors++; $display("FAIL overrun_flag%0d: got %b want %b", i, ovr0, exp_ovr); end
      end
      errc0 = 1'b1;
      @(negedge clk);
      errc0 = 1'b0;
      checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", ovr0); end
   endtask

   // Continues from the full FIFO left by test_overrun.
   task automatic test_full_pushpop();
      int n;
      bit ok;
      logic [9:0] v;
      nxt[0] = 10'($urandom);
      wait_sig(0, DIV0 + 2, n, ok);
      wait_sig(1, ADC_LAT + 10, n, ok);
      bus0.sample_ready = 1'b1;   // pop lands in the push cycle
      void'(exp_q.pop_front());
      v = (ret0.size() > 0) ? ret0.pop_front() : 10'h0;
      exp_q.push_back(v);
      @(negedge clk);
      bus0.sample_ready = 1'b0;
      checks++; if (!ok || lvl0 !== 3'd4) begin errors++; $display("FAIL fullpp_level: got %0d want 4", lvl0); end
      checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL fullpp_overrun: got %b want 0", ovr0); end
      bus0.sample_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         v = exp_q.pop_front();
         checks++; if (bus0.sample_valid !== 1'b1 || bus0.sample_data !== v) begin errors++; $display("FAIL fullpp_drain%0d: got v=%b d=%h want v=1 d=%h", i, bus0.sample_valid, bus0.sample_data, v); end
         @(negedge clk);
      end
      bus0.sample_ready = 1'b0;
      checks++; if (lvl0 !== 3'd0 || bus0.sample_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty: got lvl=%0d v=%b want 0 0", lvl0, bus0.sample_valid); end
      run0 = 1'b0;
   endtask

   task automatic test_missed();
      int n, t1, gap;
      bit ok;
      logic [9:0] v;
      do_reset();
      bus1.sample_ready = 1'b1;
      run1 = 1'b1;
      gap = ((ADC_LAT + 3 + DIV1 - 1) / DIV1) * DIV1;
      wait_sig(3, 4, n, ok);
      t1 = cyc;
      for (int i = 0; i < 2; i++) begin
         wait_sig(4, ADC_LAT + 10, n, ok);
         @(negedge clk);
         v = (ret1.size() > 0) ? ret1.pop_front() : 10'h0;
         checks++; if (!ok || bus1.sample_valid !== 1'b1 || bus1.sample_data !== v) begin errors++; $display("FAIL missed_sample%0d: got v=%b d=%h want v=1 d=%h", i, bus1.sample_valid, bus1.sample_data, v); end
         checks++; if (mis1 !== (DIV1 <= ADC_LAT + 2)) begin errors++; $display("FAIL missed_flag%0d: got %b want %b", i, mis1, DIV1 <= ADC_LAT + 2); end
         nxt[1] = 10'($urandom);
         wait_sig(3, gap + 10, n, ok);
         checks++; if (!ok || cyc - t1 != gap) begin errors++; $display("FAIL missed_gap%0d: got %0d want %0d", i, cyc - t1, gap); end
         t1 = cyc;
      end
      checks++; if ({ovr1, tmo1} !== 2'b00) begin errors++; $display("FAIL missed_other_flags: got %b want 00", {ovr1, tmo1}); end
      run1 = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n;
      bit ok;
      logic [9:0] v;
      do_reset();
      run0 = 1'b1;
      wait_sig(0, 4, n, ok);
      repeat (201) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if ({bus0.adc_enable, bus0.adc_clear_available, bus0.sample_valid} !== 3'b000) begin errors++; $display("FAIL rstmid_pulses: got %b want 000", {bus0.adc_enable, bus0.adc_clear_available, bus0.sample_valid}); end
      checks++; if (lvl0 !== 3'd0 || bus0.sample_data !== 10'h0 || {ovr0, mis0, tmo0} !== 3'b000) begin errors++; $display("FAIL rstmid_state: got lvl=%0d d=%h f=%b want 0 000 000", lvl0, bus0.sample_data, {ovr0, mis0, tmo0}); end
      ret0.delete();
      nxt[0] = 10'($urandom);
      rst = 1'b0;
      wait_sig(0, 3, n, ok);
      checks++; if (!ok || n != 1) begin errors++; $display("FAIL rstmid_first_tick: got %0d want 1", n); end
      @(negedge clk);
      checks++; if (lvl0 !== 3'd0) begin errors++; $display("FAIL rstmid_stale_capture: got lvl=%0d want 0", lvl0); end
      wait_sig(1, ADC_LAT + 10, n, ok);
      checks++; if (!ok || lvl0 !== 3'd0) begin errors++; $display("FAIL rstmid_pre_sample: got lvl=%0d want 0", lvl0); end
      @(negedge clk);
      v = (ret0.size() > 0) ? ret0.pop_front() : 10'h0;
      checks++; if (lvl0 !== 3'd1 || bus0.sample_data !== v) begin errors++; $display("FAIL rstmid_sample: got lvl=%0d d=%h want 1 %h", lvl0, bus0.sample_data, v); end
      run0 = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_timeout();
      test_overrun();
      test_full_pushpop();
      test_missed();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
